axis_tag_broadcast_fifo: RTL

Successor to the unbuffered time-tag broadcaster. It fans one tag stream out to FANOUT consumers through a per-output FIFO of DEPTH words, so consumers are decoupled from each other. Each output has a run-time channel-enable mask that strips unwanted events. A selectable mode either back-pressures the source or drops words and counts them. It sits between the tag ingress and the measurement blocks, so slow or stalled consumers no longer stall the others.

---
 rtl/axis_tag_broadcast_fifo.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_tag_broadcast_fifo.sv
// Purpose: circular-buffer FIFO of DEPTH entries. Pushes are ignored when full, pops when empty.
// Latency: a word pushed at edge N is at the head after edge N. No bypass from push to pop.
// Backpressure: exports full/empty only; the caller gates push and pop.
module axis_tag_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are meaningless until the count covers them, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap modulo DEPTH; the count tracks occupancy, unchanged on push+pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: fan one tag stream out to FANOUT buffered consumers with per-output channel filtering.
// Latency: one cycle from accept to output valid; one word per cycle per output.
// Backpressure: DROP_ON_FULL=0 stalls the source while any FIFO is full; =1 never stalls and counts drops.
module axis_tag_broadcast_fifo #(
    parameter int FANOUT        = 2,
    parameter int DEPTH         = 16,
    parameter int WORD_WIDTH    = 4,
    parameter int TIME_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 6,
    parameter int NUM_CHANNELS  = 18,
    parameter int DROP_ON_FULL  = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       s_tvalid,
    input  logic [WORD_WIDTH*TIME_WIDTH-1:0]           s_tagtime,
    input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0]        s_channel,
    input  logic [WORD_WIDTH-1:0]                      s_tkeep,
    input  logic [TIME_WIDTH-1:0]                      s_lowest_time_bound,
    output logic                                       s_tready,
    input  logic [FANOUT*2*NUM_CHANNELS-1:0]           chan_mask,
    output logic [FANOUT-1:0]                          m_tvalid,
    output logic [FANOUT*WORD_WIDTH*TIME_WIDTH-1:0]    m_tagtime,
    output logic [FANOUT*WORD_WIDTH*CHANNEL_WIDTH-1:0] m_channel,
    output logic [FANOUT*WORD_WIDTH-1:0]               m_tkeep,
    output logic [FANOUT*TIME_WIDTH-1:0]               m_lowest_time_bound,
    input  logic [FANOUT-1:0]                          m_tready,
    output logic [FANOUT*32-1:0]                       drop_count,
    output logic [FANOUT-1:0]                          overflow
);
    localparam int M    = 2 * NUM_CHANNELS;
    localparam int IDXW = (M > 1) ? $clog2(M) : 1;

    typedef struct packed {
        logic [WORD_WIDTH*TIME_WIDTH-1:0]    tagtime;
        logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] channel;
        logic [WORD_WIDTH-1:0]               keep;
        logic [TIME_WIDTH-1:0]               bound;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic                                  ready_en;
    logic                                  accept;
    logic [FANOUT-1:0]                     full_vec;
    logic [FANOUT-1:0][M-1:0]              omask;
    logic [FANOUT-1:0][WORD_WIDTH-1:0]     keep_bits;

    assign omask  = chan_mask;
    assign accept = s_tvalid && s_tready;

    // Hold s_tready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // In drop mode the source is never stalled; otherwise any full FIFO stalls it.
    assign s_tready = ready_en && ((DROP_ON_FULL != 0) || !(|full_vec));

    // Per-slot channel decode: rising edges map to ch-1, falling edges to NUM_CHANNELS+|ch|-1.
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_slot
        logic signed [CHANNEL_WIDTH-1:0] ch;
        logic                            ok;
        logic [IDXW-1:0]                 idx;

        assign ch = s_channel[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH];

        // Channel 0 and magnitudes beyond NUM_CHANNELS never match any mask bit.
        always_comb begin
            ok  = 1'b0;
            idx = '0;
            if (ch > 0) begin
                ok  = (int'(ch) <= NUM_CHANNELS);
                idx = IDXW'(int'(ch) - 1);
            end else if (ch < 0) begin
                ok  = ((-int'(ch)) <= NUM_CHANNELS);
                idx = IDXW'(NUM_CHANNELS - int'(ch) - 1);
            end
        end

        for (genvar go = 0; go < FANOUT; go++) begin : g_mask
            assign keep_bits[go][gi] = s_tkeep[gi] && ok && omask[go][idx];
        end
    end

    // One buffered lane per consumer; every accepted word is pushed, even with no kept slot.
    for (genvar go = 0; go < FANOUT; go++) begin : g_out
        entry_t                  wr_entry;
        entry_t                  head;
        logic                    full;
        logic                    empty;
        logic                    push;
        logic                    pop;
        logic                    drop;
        logic [TIME_WIDTH-1:0]   last_bound;
        logic [31:0]             drop_cnt;
        logic                    ovf;

        assign wr_entry.tagtime = s_tagtime;
        assign wr_entry.channel = s_channel;
        assign wr_entry.keep    = keep_bits[go];
        assign wr_entry.bound   = s_lowest_time_bound;

        assign push = accept && !full;
        assign drop = accept && full;
        assign pop  = !empty && m_tready[go];

        assign full_vec[go] = full;

        axis_tag_fifo #(
            .W     (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push),
            .push_dat (wr_entry),
            .pop      (pop),
            .head     (head),
            .full     (full),
            .empty    (empty)
        );

        // Remember the newest bound so an empty lane still advertises progress.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last_bound <= '0;
            end else if (push) begin
                last_bound <= s_lowest_time_bound;
            end
        end

        // Saturating drop counter and sticky overflow; only reachable in drop mode.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_cnt <= '0;
                ovf      <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 32'd1;
                end
            end
        end

        assign m_tvalid[go] = !empty;
        assign m_tagtime[go*WORD_WIDTH*TIME_WIDTH +: WORD_WIDTH*TIME_WIDTH]         = head.tagtime;
        assign m_channel[go*WORD_WIDTH*CHANNEL_WIDTH +: WORD_WIDTH*CHANNEL_WIDTH]   = head.channel;
        assign m_tkeep[go*WORD_WIDTH +: WORD_WIDTH] = empty ? '0 : head.keep;
        assign m_lowest_time_bound[go*TIME_WIDTH +: TIME_WIDTH] = empty ? last_bound : head.bound;
        assign drop_count[go*32 +: 32] = drop_cnt;
        assign overflow[go]            = ovf;
    end
endmodule
